// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, GF(2^8) constants and arithmetic helpers.
package aes_pkg;

    typedef logic [0:15][7:0] state_t;
    typedef logic [0:3][7:0]  col_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mc_state_e;

    // AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [8:0] GF_POLY = 9'h11B;

    // First matrix row; row r is this row rotated right by r
    localparam logic [0:3][3:0] FWD_ROW = {4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [0:3][3:0] INV_ROW = {4'he, 4'hb, 4'hd, 4'h9};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // Multiply by a small constant; every MixColumns coefficient fits in 4 bits
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational (Inv)MixColumns on one 4-byte column.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  logic [0:3][7:0] col_i,
    input  logic            inv_i,
    output logic [0:3][7:0] col_o
);

    // out[r] = XOR over k of coef[(k - r) mod 4] * in[k]
    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                col_o[r] = col_o[r] ^ gf_mul(col_i[k],
                    inv_i ? INV_ROW[2'(k - r)] : FWD_ROW[2'(k - r)]);
            end
        end
    end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES (Inv)MixColumns: one block accepted, processed COLS_PER_CYCLE
// columns per cycle, then held in a result register until taken.
module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             inv_i,
    input  logic [0:15][7:0] state_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [0:15][7:0] state_o
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter value of the beat that handles the final columns
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

    mc_state_e state_q, state_d;
    logic [1:0] cnt_q;
    state_t     in_q;
    state_t     res_q;
    logic       inv_q;
    logic       accept;
    logic       last_beat;

    logic [COLS_PER_CYCLE-1:0][0:3][7:0] col_in;
    logic [COLS_PER_CYCLE-1:0][0:3][7:0] col_out;

    assign accept    = valid_i && ready_o;
    assign last_beat = (cnt_q == LAST_CNT);
    assign state_o   = res_q;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        logic [1:0] cidx;
        assign cidx      = cnt_q + 2'(g);
        assign col_in[g] = in_q[{cidx, 2'b00} +: 4];

        aes_mix_single_column u_col (
            .col_i (col_in[g]),
            .inv_i (inv_q),
            .col_o (col_out[g])
        );
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs; DONE can hand off and accept on the same edge
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (last_beat) state_d = S_DONE;
            end
            S_DONE: begin
                valid_o = 1'b1;
                ready_o = ready_i;
                if (ready_i) state_d = valid_i ? S_BUSY : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture on acceptance, then fill the result register column group by group
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q  <= '0;
            inv_q <= 1'b0;
            cnt_q <= 2'd0;
            res_q <= '0;
        end else if (accept) begin
            in_q  <= state_i;
            inv_q <= inv_i;
            cnt_q <= 2'd0;
        end else if (state_q == S_BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                res_q[{cnt_q + 2'(g), 2'b00} +: 4] <= col_out[g];
            end
            // Hold on the last beat so the counter only restarts on acceptance
            if (!last_beat) cnt_q <= cnt_q + STEP;
        end
    end

endmodule

// File: doc/aes_mix_columns_iter.md
AES_MIX_COLUMNS_ITER -- requirements
Module: aes_mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning columns processed per cycle; legal values 1, 2, 4; others SHALL fail elaboration.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  input block valid.
REQ-005 SHALL have port ready_o  output  1  module can accept a block.
REQ-006 SHALL have port inv_i  input  1  mode: 0 = MixColumns, 1 = InvMixColumns; sampled with the block.
REQ-007 SHALL have port state_i  input  16x8 ([0:15][7:0])  input state; byte 4c+r = column c, row r.
REQ-008 SHALL have port valid_o  output  1  result valid.
REQ-009 SHALL have port ready_i  input  1  downstream accepts result.
REQ-010 SHALL have port state_o  output  16x8 ([0:15][7:0])  result state, same byte ordering.

Function
REQ-011 Input handshake SHALL occur on a rising edge where valid_i && ready_o; output handshake where valid_o && ready_i.
REQ-012 FSM SHALL have states IDLE, BUSY, DONE.
REQ-013 IDLE: ready_o=1, valid_o=0; on input handshake capture state_i and inv_i, clear column counter, go BUSY.
REQ-014 BUSY: ready_o=0, valid_o=0; each cycle transform COLS_PER_CYCLE columns starting at counter, write them to the result register, advance counter by COLS_PER_CYCLE.
REQ-015 BUSY SHALL last NB = 4/COLS_PER_CYCLE cycles; on the edge processing the last columns go DONE.
REQ-016 Latency: input handshake on edge T SHALL give valid_o=1 after edge T+NB (T+4, T+2, T+1 for COLS_PER_CYCLE 1, 2, 4).
REQ-017 DONE: valid_o=1; state_o and valid_o SHALL stay stable while ready_i=0.
REQ-018 DONE with ready_i=1: ready_o SHALL be 1 (ready_o = IDLE || (DONE && ready_i)); same-edge input handshake SHALL go BUSY with the new block; otherwise go IDLE.
REQ-019 Sustained throughput SHALL be one block per NB+1 cycles.
REQ-020 MixColumns SHALL use GF(2^8) poly 0x11B, matrix rows {02 03 01 01} rotated; InvMixColumns matrix rows {0e 0b 0d 09} rotated.
REQ-021 The mode captured at acceptance SHALL apply to all columns of that block; inv_i changes during BUSY SHALL be ignored.
REQ-022 valid_i during BUSY or DONE (without ready_i) SHALL be ignored; no block is dropped or duplicated.
REQ-023 state_o SHALL come directly from registers (no combinational path from state_i).

Reset
REQ-024 rst_i=1 on an edge SHALL force IDLE, counter 0, valid_o 0, state_o 16'h00 bytes, captured mode 0; ready_o=1 in the following cycle.
REQ-025 Reset mid-BUSY or mid-DONE SHALL abandon the block with no output handshake; rst_i SHALL override a simultaneous input handshake.

Structure
REQ-026 Shared package aes_pkg SHALL hold state_t typedef (logic [0:15][7:0]), column typedef, the GF poly constant, and xtime/gf-multiply functions.
REQ-027 A combinational sub-module aes_mix_single_column (4-byte column in, inv input, 4-byte out) SHALL be instantiated COLS_PER_CYCLE times.
REQ-028 FSM, counter and result register SHALL be in aes_mix_columns_iter; the counter is 2 bits and wraps only via reset or acceptance.

Verification
REQ-029 Forward: column 0 = db 13 53 45, others c6 c6 c6 c6, inv=0 -> state_o col 0 = 8e 4d a1 bc, others c6 c6 c6 c6, valid_o after edge T+NB.
REQ-030 Inverse: columns 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, 4d 7e bd f8, inv=1 -> db 13 53 45, f2 0a 22 5c, 01 01 01 01, 2d 26 31 4c.
REQ-031 Backpressure: ready_i=0 for 5 cycles in DONE -> state_o/valid_o unchanged; valid_i held high not accepted; accepted on edge ready_i rises.
REQ-032 Back-to-back: valid_i=1, ready_i=1 continuously, 3 blocks -> 3 correct results, one per NB+1 cycles, in order.
REQ-033 Reset mid-BUSY at second beat (COLS_PER_CYCLE=1) -> valid_o stays 0, ready_o=1 next cycle, subsequent block d4 d4 d4 d5 -> d5 d5 d7 d6.
REQ-034 Random: all COLS_PER_CYCLE values, 1000 random blocks, random mode, random ready_i -> all match software reference model.
